// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, issue hazard check, stall counter, sticky writeback-underflow flag.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle final writeback clear a source hazard.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (flush)        cnt <= '0;
    else if (inc && !dec)  cnt <= cnt + 1'b1;
    else if (dec && !inc)  cnt <= cnt - 1'b1;
  end
endmodule

module reg_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rs,
  input  logic [4:0]         issue_rt,
  input  logic [4:0]         issue_rd,
  input  logic               issue_wen,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  output logic [31:0]        busy_mask,
  output logic [STALL_W-1:0] stall_count,
  output logic               wb_err
);
  logic [31:0][CNT_W-1:0] cnt;
  logic [31:0]            src_busy;
  logic [31:0]            cnt_max;
  logic                   hazard;
  logic                   accept_wr;
  logic                   underflow;

  assign accept_wr = issue_valid && issue_ready && issue_wen && (issue_rd != 5'd0);

  genvar r;
  generate
    for (r = 0; r < 32; r++) begin : g_reg
      if (r == 0) begin : g_zero
        assign cnt[r] = '0;
      end else begin : g_cnt
        logic inc, dec;
        assign inc = accept_wr && (issue_rd == 5'(r));
        // Underflowing writebacks leave the count alone; they only raise wb_err.
        assign dec = wb_valid && (wb_rd == 5'(r)) && busy_mask[r];
        reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
          .clk(clk), .reset(reset), .flush(flush),
          .inc(inc), .dec(dec), .cnt(cnt[r])
        );
      end
      assign busy_mask[r] = |cnt[r];
      assign cnt_max[r]   = &cnt[r];
`ifdef SB_WB_BYPASS_EN
      // Last outstanding write retiring now wakes dependent sources this cycle.
      assign src_busy[r] = busy_mask[r] &&
                           !(wb_valid && (wb_rd == 5'(r)) && (cnt[r] == CNT_W'(1)));
`else
      assign src_busy[r] = busy_mask[r];
`endif
    end
  endgenerate

  always_comb begin
    hazard = 1'b0;
    if (issue_valid) begin
      if ((issue_rs != 5'd0) && src_busy[issue_rs])                hazard = 1'b1;
      if ((issue_rt != 5'd0) && src_busy[issue_rt])                hazard = 1'b1;
      if (issue_wen && (issue_rd != 5'd0) && cnt_max[issue_rd])    hazard = 1'b1;
    end
  end

  assign issue_ready = !hazard && !flush;
  assign underflow   = wb_valid && (wb_rd != 5'd0) && !busy_mask[wb_rd] && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      wb_err      <= 1'b0;
    end else begin
      if (issue_valid && !issue_ready && !(&stall_count))
        stall_count <= stall_count + 1'b1;
      if (underflow)
        wb_err <= 1'b1;
    end
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter; max outstanding writes per register is 2^CNT_W-1.
REQ-002 Parameter STALL_W, default 16: width of the stall-cycle counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  discard all pending writes (pipeline flush).
REQ-006 issue_valid  input  1  instruction requests issue.
REQ-007 issue_rs  input  5  source register 1.
REQ-008 issue_rt  input  5  source register 2.
REQ-009 issue_rd  input  5  destination register.
REQ-010 issue_wen  input  1  instruction will write issue_rd.
REQ-011 issue_ready  output  1  issue accepted this cycle when issue_valid=1 (combinational).
REQ-012 wb_valid  input  1  writeback completing this cycle.
REQ-013 wb_rd  input  5  register being written back.
REQ-014 busy_mask  output  32  bit r = 1 when register r has a nonzero pending count.
REQ-015 stall_count  output  STALL_W  saturating count of stalled issue cycles.
REQ-016 wb_err  output  1  sticky flag: writeback to a register with zero pending count.

Function
REQ-017 Block SHALL hold one CNT_W-bit pending counter per register 1..31; register 0 SHALL never be busy and SHALL never be counted.
REQ-018 busy_mask[r] SHALL equal (cnt[r] != 0), derived from registered state only; busy_mask[0] = 0 always.
REQ-019 Hazard SHALL be raised when issue_valid=1 and any of: rs!=0 and rs busy; rt!=0 and rt busy; issue_wen=1, rd!=0 and cnt[rd] at maximum.
REQ-020 issue_ready SHALL be 0 when hazard or flush is 1, else 1; issue_ready is independent of issue_valid except via hazard.
REQ-021 Accepted issue (issue_valid & issue_ready) with issue_wen=1 and rd!=0 SHALL increment cnt[rd] at the next edge.
REQ-022 wb_valid=1 with wb_rd!=0 and cnt[wb_rd]>0 SHALL decrement cnt[wb_rd] at the next edge; wb_rd=0 SHALL be ignored.
REQ-023 Accepted issue and valid writeback to the same register in one cycle SHALL leave that count unchanged.
REQ-024 wb_valid=1 with wb_rd!=0 and cnt[wb_rd]=0 SHALL leave the count at 0 and set wb_err at the next edge; wb_err stays 1 until reset.
REQ-025 flush=1 SHALL zero every counter at the next edge, overriding same-cycle issue and writeback; writeback during flush SHALL NOT set wb_err.
REQ-026 stall_count SHALL increment by 1 each cycle with issue_valid=1 and issue_ready=0, saturating at all-ones.
REQ-027 Issue-to-busy latency SHALL be 1 cycle; writeback-to-not-busy latency SHALL be 1 cycle (without bypass).

Reset
REQ-028 While reset=1, all counters, busy_mask, stall_count and wb_err SHALL be 0 immediately, independent of clk.
REQ-029 After reset release with flush=0, issue_ready SHALL be 1 for any issue request.
REQ-030 Reset asserted mid-operation SHALL discard all pending writes; no writeback-underflow is flagged for writebacks arriving after release only if counts are nonzero.

Configuration
REQ-031 Macro SB_WB_BYPASS_EN: when defined, a register with cnt=1 receiving a valid writeback in the current cycle SHALL be treated as not busy for REQ-019 source checks (same-cycle wakeup).
REQ-032 Without SB_WB_BYPASS_EN, hazard evaluation SHALL use registered counts only; busy_mask is unaffected by the macro in both cases.

Verification
REQ-033 Reset, issue rd=5 wen=1 -> next cycle busy_mask=32'h0000_0020; issue rs=5 -> issue_ready=0, stall_count=1 after one cycle.
REQ-034 rd=5 pending, wb_valid wb_rd=5 and issue rs=5 same cycle -> with SB_WB_BYPASS_EN issue_ready=1; without, issue_ready=0, then 1 next cycle.
REQ-035 Three issues rd=7 (CNT_W=2) -> cnt=3; fourth issue rd=7 wen=1 -> issue_ready=0; one wb rd=7 -> next cycle issue accepted.
REQ-036 wb_valid wb_rd=9 with nothing pending -> wb_err=1 next cycle, remains 1 until reset; issue rd=0 wen=1 -> busy_mask stays 0.
REQ-037 Registers 3,4 pending, flush=1 with simultaneous issue rd=6 -> issue_ready=0, next cycle busy_mask=0.
REQ-038 Hold issue_valid=1 with hazard for 70000 cycles (STALL_W=16) -> stall_count=16'hFFFF; assert reset mid-run -> all outputs 0 immediately.
